// File: rtl/draw_sprite_engine_pkg.sv
// Purpose: shared constants, state encoding and pixel tag type for the sprite draw engines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_sprite_engine_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;

  // Colour key: ROM entries with this value are never plotted.
  localparam logic [8:0] TRANSPARENT = 9'b111_000_111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } draw_state_t;

  // Position of one sprite pixel travelling down the pixel pipeline.
  typedef struct packed {
    logic       vld;
    logic [3:0] row;
    logic [3:0] col;
  } pix_tag_t;

endpackage

// File: rtl/draw_sprite_engine_pixel_pipe.sv
// Purpose: delays the pixel tag to meet ROM data, forms screen coordinates and qualifies the plot.
// Latency: 2 cycles from tag in to registered vga_* outputs.
// Backpressure: none; abort kills the in-flight slot and forces vga_plot low on the next edge.
// Ports: clock/reset; pix (tag of the address issued this cycle); abort; base_x/base_y (latched
//        sprite origin); rom_data (colour, valid one cycle after the address); vga_x/vga_y/
//        vga_colour/vga_plot (registered plot request).
module sprite_pixel_pipe
  import draw_sprite_engine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  pix_tag_t   pix,
  input  logic       abort,
  input  logic [8:0] base_x,
  input  logic [7:0] base_y,
  input  logic [8:0] rom_data,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       vga_plot
);

  pix_tag_t   stage1;
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic       plot_next;

  // Sums are one bit wider than the screen coordinates so an off-screen
  // pixel is clipped rather than wrapping back onto the low edge.
  always_comb begin
    sum_x     = {1'b0, base_x} + {6'd0, stage1.col};
    sum_y     = {1'b0, base_y} + {5'd0, stage1.row};
    plot_next = stage1.vld && (rom_data != TRANSPARENT) &&
                (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      stage1     <= abort ? '0 : pix;
      vga_x      <= sum_x[8:0];
      vga_y      <= sum_y[7:0];
      vga_colour <= rom_data;
      vga_plot   <= abort ? 1'b0 : plot_next;
    end
  end

endmodule

// File: rtl/draw_sprite_engine.sv
// Purpose: walks a 16x16 sprite ROM and emits clipped, colour-keyed plot requests at pos_x/pos_y.
// Latency: one pixel per cycle, pixel n plotted 2 cycles after its address; done 259 cycles after start.
// Backpressure: none; start is a 4-phase level request, dropping it mid-draw aborts without done.
// Ports: clock/reset; start (level request); pos_x/pos_y (origin, sampled when the draw begins);
//        rom_addr/rom_data (external synchronous ROM, 1-cycle read); vga_* (plot request); done.
module draw_sprite_engine
  import draw_sprite_engine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] pos_x,
  input  logic [7:0] pos_y,
  output logic [7:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);

  localparam logic [7:0] LAST_PIX = 8'(SPRITE_DIM * SPRITE_DIM - 1);

  draw_state_t state, state_nxt;
  logic [7:0]  counter;
  logic        flush_cnt;
  logic [8:0]  base_x;
  logic [7:0]  base_y;
  logic        abort;
  pix_tag_t    pix;

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_DRAW;
      S_DRAW: begin
        if (!start) begin
          state_nxt = S_IDLE;
          abort     = 1'b1;
        end else if (counter == LAST_PIX) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!start) begin
          state_nxt = S_IDLE;
          abort     = 1'b1;
        end else if (flush_cnt) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      flush_cnt <= 1'b0;
      base_x    <= '0;
      base_y    <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_x  <= pos_x;
            base_y  <= pos_y;
            counter <= '0;
          end
        end
        S_DRAW: begin
          counter   <= counter + 8'd1;
          flush_cnt <= 1'b0;
        end
        S_FLUSH: flush_cnt <= ~flush_cnt;
        default: ;
      endcase
      // Registered done: rises one cycle into S_DONE (259 cycles after the
      // start-sampling edge) and falls together with the return to S_IDLE.
      done <= (state == S_DONE) && (state_nxt == S_DONE);
    end
  end

  assign rom_addr = counter;

  // Only addresses issued while the request is still held are real pixels.
  assign pix = '{vld: (state == S_DRAW) && start, row: counter[7:4], col: counter[3:0]};

  sprite_pixel_pipe u_pipe (
    .clock      (clock),
    .reset      (reset),
    .pix        (pix),
    .abort      (abort),
    .base_x     (base_x),
    .base_y     (base_y),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule
